// File: rtl/seq_div_32.sv
// Multi-cycle 32-bit restoring divider (unsigned / signed truncating) with divide-by-zero
// reporting. Each iteration drives one ripple-carry add/sub unit in subtract mode.

module addsub_32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sna_i,
    output logic [WIDTH-1:0] s_o,
    output logic             co_o
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] bx;

    assign c[0] = sna_i;
    assign bx   = b_i ^ {WIDTH{sna_i}};

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ bx[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & bx[i]) | (c[i] & (a_i[i] ^ bx[i]));
    end

    assign co_o = c[WIDTH];
endmodule

module seq_div_32 #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] r_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o
);
    localparam int CW = $clog2(ITER);

    // LOAD registers the operand magnitudes and the B==0 decision one cycle after
    // capture, keeping the negation off the input pins.
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_FIX, S_ZERO, S_DONE
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             sgn_q;
    logic [WIDTH:0]   p_q;
    logic [WIDTH-1:0] d_q, m_q;
    logic [WIDTH-1:0] q_q, r_q;
    logic             dz_q, busy_q, done_q;

    logic [WIDTH:0]   p_sh, p_d;
    logic [WIDTH-1:0] d_d, trial;
    logic             co, nb;
    logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;

    assign p_sh = {p_q[WIDTH-1:0], d_q[WIDTH-1]};

    addsub_32 #(.WIDTH(WIDTH)) u_sub (
        .a_i   (p_sh[WIDTH-1:0]),
        .b_i   (m_q),
        .sna_i (1'b1),
        .s_o   (trial),
        .co_o  (co)
    );

    always_comb begin
        nb    = co | p_sh[WIDTH];
        p_d   = nb ? {1'b0, trial} : p_sh;
        d_d   = {d_q[WIDTH-2:0], nb};
        a_mag = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
        b_mag = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
        q_fix = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -d_q : d_q;
        r_fix = (sgn_q && a_q[WIDTH-1]) ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            p_q     <= '0;
            d_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start_i) begin
                    a_q     <= a_i;
                    b_q     <= b_i;
                    sgn_q   <= signed_i;
                    dz_q    <= 1'b0;
                    busy_q  <= 1'b1;
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    if (b_q == '0) begin
                        state_q <= S_ZERO;
                    end else begin
                        cnt_q   <= '0;
                        p_q     <= '0;
                        d_q     <= a_mag;
                        m_q     <= b_mag;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    p_q   <= p_d;
                    d_q   <= d_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(ITER - 1)) state_q <= S_FIX;
                end
                S_FIX: begin
                    q_q     <= q_fix;
                    r_q     <= r_fix;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_ZERO: begin
                    q_q     <= '1;
                    r_q     <= a_q;
                    dz_q    <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign q_o        = q_q;
    assign r_o        = r_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign div_zero_o = dz_q;
endmodule
